// File: rtl/adxl345_spi_responder.sv
// ADXL345 register-interface emulator: SPI mode 3 responder that serves DEVID,
// the three configuration registers and a coherent snapshot of x/y/z samples.
// All SPI pins are oversampled in the sys_clk domain.
`timescale 1ns/1ps
module adxl345_spi_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID_VALUE = 8'hE5
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        spi_sclk,
  input  logic        spi_cs,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  input  logic [15:0] x_axis,
  input  logic [15:0] y_axis,
  input  logic [15:0] z_axis,
  output logic [7:0]  bw_rate,
  output logic [7:0]  power_ctl,
  output logic [7:0]  data_format,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  localparam logic [5:0] ADDR_DEVID   = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE = 6'h2C;
  localparam logic [5:0] ADDR_PWR_CTL = 6'h2D;
  localparam logic [5:0] ADDR_DATA_FMT = 6'h31;

  // The extra top bit of the sclk/cs pipes holds the previous synchronised
  // sample, so edge detection compares the last two synchronised values.
  logic [SYNC_STAGES:0]   sclk_pipe;
  logic [SYNC_STAGES:0]   cs_pipe;
  logic [SYNC_STAGES-1:0] mosi_pipe;

  logic sclk_s, sclk_p, cs_s, cs_p, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift_in;
  logic [7:0]  shift_out;
  logic [5:0]  addr_q;
  logic        rnw_q;
  logic        mb_q;
  logic [47:0] shadow;

  logic [5:0]  cmd_addr;
  logic [7:0]  byte_in;
  logic [5:0]  next_addr;
  logic        byte_done;

  // Synchronise the SPI pins; preset to the idle (high) level.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_pipe <= '1;
      cs_pipe   <= '1;
      mosi_pipe <= '1;
    end else begin
      // NOTE: sequential state always uses <= so every flop samples the
      // pre-edge value of its neighbours; blocking here would collapse the chain.
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-1:0], spi_sclk};
      cs_pipe   <= {cs_pipe[SYNC_STAGES-1:0], spi_cs};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign sclk_s = sclk_pipe[SYNC_STAGES-1];
  assign sclk_p = sclk_pipe[SYNC_STAGES];
  assign cs_s   = cs_pipe[SYNC_STAGES-1];
  assign cs_p   = cs_pipe[SYNC_STAGES];
  assign mosi_s = mosi_pipe[SYNC_STAGES-1];

  // SCLK edges only count while cs is low; this also lets a cs rise win over
  // an SCLK edge seen in the same cycle.
  assign cs_fall   =  cs_p & ~cs_s;
  assign cs_rise   = ~cs_p &  cs_s;
  assign sclk_rise = ~cs_s &  sclk_s & ~sclk_p;
  assign sclk_fall = ~cs_s & ~sclk_s &  sclk_p;

  assign cmd_addr  = {shift_in[4:0], mosi_s};
  assign byte_in   = {shift_in, mosi_s};
  assign next_addr = mb_q ? addr_q + 6'd1 : addr_q;
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);

  // Read-side register map.
  function automatic logic [7:0] reg_read(input logic [5:0] a);
    case (a)
      ADDR_DEVID:    reg_read = DEVID_VALUE;
      ADDR_BW_RATE:  reg_read = bw_rate;
      ADDR_PWR_CTL:  reg_read = power_ctl;
      ADDR_DATA_FMT: reg_read = data_format;
      6'h32:         reg_read = shadow[7:0];
      6'h33:         reg_read = shadow[15:8];
      6'h34:         reg_read = shadow[23:16];
      6'h35:         reg_read = shadow[31:24];
      6'h36:         reg_read = shadow[39:32];
      6'h37:         reg_read = shadow[47:40];
      default:       reg_read = 8'h00;
    endcase
  endfunction

  // Transaction state register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: cs rise aborts from anywhere.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    if (cs_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (cs_fall)   state_d = CMD;
        CMD:     if (byte_done) state_d = DATA;
        DATA:    state_d = DATA;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: shifting, register file, MISO drive and write reporting.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shadow and shift registers are reset too, even though each
      // transaction reloads them, so reads never expose X after power-up.
      bit_cnt     <= '0;
      shift_in    <= '0;
      shift_out   <= '0;
      addr_q      <= '0;
      rnw_q       <= 1'b0;
      mb_q        <= 1'b0;
      shadow      <= '0;
      bw_rate     <= 8'h0A;
      power_ctl   <= 8'h00;
      data_format <= 8'h00;
      spi_miso    <= 1'b1;
      spi_miso_oe <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (cs_rise) begin
        spi_miso_oe <= 1'b0;
        spi_miso    <= 1'b1;
        bit_cnt     <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (cs_fall) begin
              shadow  <= {z_axis, y_axis, x_axis};
              bit_cnt <= '0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              shift_in <= {shift_in[5:0], mosi_s};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rnw_q     <= shift_in[6];
                mb_q      <= shift_in[5];
                addr_q    <= cmd_addr;
                shift_out <= reg_read(cmd_addr);
              end
            end
          end
          DATA: begin
            if (sclk_fall && rnw_q) begin
              spi_miso_oe <= 1'b1;
              spi_miso    <= shift_out[7];
              shift_out   <= {shift_out[6:0], 1'b0};
            end
            if (sclk_rise) begin
              shift_in <= {shift_in[5:0], mosi_s};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (!rnw_q) begin
                  case (addr_q)
                    ADDR_BW_RATE:  bw_rate     <= byte_in;
                    ADDR_PWR_CTL:  power_ctl   <= byte_in;
                    ADDR_DATA_FMT: data_format <= byte_in;
                    default: ;
                  endcase
                  if (addr_q inside {ADDR_BW_RATE, ADDR_PWR_CTL, ADDR_DATA_FMT}) begin
                    wr_strobe <= 1'b1;
                    wr_addr   <= addr_q;
                    wr_data   <= byte_in;
                  end
                end
                addr_q    <= next_addr;
                shift_out <= reg_read(next_addr);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// Self-checking bench for adxl345_spi_responder: directed plan followed by
// randomised transactions, checked against a register-array model.
`timescale 1ns/1ps
module tb_adxl345_spi_responder;

  localparam int HALF = 80;  // SCLK half period: 8 sys_clk cycles

  logic        sys_clk, rst_n;
  logic        spi_sclk, spi_cs, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic [15:0] x_axis, y_axis, z_axis;
  logic [7:0]  bw_rate, power_ctl, data_format;
  logic        wr_strobe;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;

  adxl345_spi_responder dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .spi_sclk    (spi_sclk),
    .spi_cs      (spi_cs),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .x_axis      (x_axis),
    .y_axis      (y_axis),
    .z_axis      (z_axis),
    .bw_rate     (bw_rate),
    .power_ctl   (power_ctl),
    .data_format (data_format),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int exp_strobes = 0;

  // Behavioural model: the whole 64-entry address space as a byte array.
  logic [7:0] model_mem [64];
  logic [5:0] exp_wr_addr;
  logic [7:0] exp_wr_data;
  logic [7:0] rx_log [$];

  // Counts every sys_clk cycle wr_strobe is high, so a wide pulse over-counts.
  always @(negedge sys_clk) if (wr_strobe === 1'b1) strobe_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (model_mem[i]) model_mem[i] = 8'h00;
    model_mem[6'h00] = 8'hE5;
    model_mem[6'h2C] = 8'h0A;
    exp_wr_addr = 6'h00;
    exp_wr_data = 8'h00;
  endtask

  function automatic bit writable(input logic [5:0] a);
    return (a == 6'h2C) || (a == 6'h2D) || (a == 6'h31);
  endfunction

  // Mode 3 master: drive on SCLK fall, sample MISO just before SCLK rise.
  task automatic spi_bits(input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx, output logic oe_all, output logic oe_any);
    rx = 8'h00;
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_sclk = 1'b0;
      spi_mosi = tx[7-i];
      #HALF;
      rx[7-i] = spi_miso;
      oe_all  = oe_all & spi_miso_oe;
      oe_any  = oe_any | spi_miso_oe;
      spi_sclk = 1'b1;
      #HALF;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_oe"}, 32'(spi_miso_oe), 32'(1'b0));
    check({tag, "_miso"}, 32'(spi_miso), 32'(1'b1));
    check({tag, "_bw"}, 32'(bw_rate), 32'(model_mem[6'h2C]));
    check({tag, "_pc"}, 32'(power_ctl), 32'(model_mem[6'h2D]));
    check({tag, "_df"}, 32'(data_format), 32'(model_mem[6'h31]));
    check({tag, "_strobes"}, 32'(strobe_cnt), 32'(exp_strobes));
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'(exp_wr_addr));
    check({tag, "_wr_data"}, 32'(wr_data), 32'(exp_wr_data));
  endtask

  // One transaction: command, nbytes data bytes (last one may be cut short),
  // optional x_axis change after data byte chg_after.
  task automatic txn(input string tag, input logic [7:0] cmd, input int nbytes,
                     input int last_bits, input logic [7:0] wdata0,
                     input int chg_after, input logic [15:0] chg_x);
    logic [7:0] rx, tx;
    logic       oe_all, oe_any;
    logic [5:0] a;
    int         nb;
    model_mem[6'h32] = x_axis[7:0];
    model_mem[6'h33] = x_axis[15:8];
    model_mem[6'h34] = y_axis[7:0];
    model_mem[6'h35] = y_axis[15:8];
    model_mem[6'h36] = z_axis[7:0];
    model_mem[6'h37] = z_axis[15:8];
    spi_cs = 1'b0;
    #(2*HALF);
    spi_bits(cmd, 8, rx, oe_all, oe_any);
    check({tag, "_cmd_oe"}, 32'(oe_any), 32'(1'b0));
    a = cmd[5:0];
    for (int b = 0; b < nbytes; b++) begin
      nb = (b == nbytes - 1) ? last_bits : 8;
      tx = (b == 0) ? wdata0 : 8'($urandom_range(0, 255));
      spi_bits(tx, nb, rx, oe_all, oe_any);
      if (nb == 8) begin
        if (cmd[7]) begin
          check($sformatf("%s_rd%02h", tag, a), 32'(rx), 32'(model_mem[a]));
          check({tag, "_rd_oe"}, 32'(oe_all), 32'(1'b1));
          rx_log.push_back(rx);
        end else begin
          check({tag, "_wr_oe"}, 32'(oe_any), 32'(1'b0));
          if (writable(a)) begin
            model_mem[a] = tx;
            exp_wr_addr = a;
            exp_wr_data = tx;
            exp_strobes++;
          end
        end
        if (cmd[6]) a = a + 6'd1;
      end
      if (b == chg_after) x_axis = chg_x;
    end
    #HALF;
    spi_cs = 1'b1;
    #200;
    check_idle(tag);
  endtask

  logic [5:0] picks [12] = '{6'h00, 6'h2C, 6'h2D, 6'h31, 6'h32, 6'h33,
                             6'h34, 6'h35, 6'h36, 6'h37, 6'h3F, 6'h10};

  initial begin
    logic [7:0] rx;
    logic       oe_all, oe_any;
    logic [7:0] cmd;
    int         nbytes, last_bits;

    rst_n = 1'b0;
    spi_sclk = 1'b1;
    spi_cs = 1'b1;
    spi_mosi = 1'b1;
    x_axis = 16'h0000;
    y_axis = 16'h0000;
    z_axis = 16'h0000;
    model_reset();
    #32;
    check_idle("reset");
    check("reset_strobe", 32'(wr_strobe), 32'(1'b0));
    rst_n = 1'b1;
    #100;

    // DEVID single read
    txn("devid", 8'h80, 1, 8, 8'h00, -1, 16'h0);
    check("devid_lit", 32'(rx_log[$]), 32'h0000_00E5);

    // Multi-byte axis read
    x_axis = 16'h1234;
    y_axis = 16'hABCD;
    z_axis = 16'h0F0E;
    txn("axes", 8'hF2, 6, 8, 8'h00, -1, 16'h0);
    check("axes_last_lit", 32'(rx_log[$]), 32'h0000_000F);

    // Snapshot coherence: x changes mid-read
    txn("snap", 8'hF2, 2, 8, 8'h00, 0, 16'h5555);
    check("snap_hi_lit", 32'(rx_log[$]), 32'h0000_0012);
    txn("snap2", 8'hF2, 2, 8, 8'h00, -1, 16'h0);
    check("snap2_lit", 32'(rx_log[$]), 32'h0000_0055);

    // Write then read back
    txn("wr_pc", 8'h2D, 1, 8, 8'h08, -1, 16'h0);
    check("wr_pc_lit", 32'(power_ctl), 32'h0000_0008);
    txn("rd_pc", 8'hAD, 1, 8, 8'h00, -1, 16'h0);

    // Ignored write, aborted write, DEVID still intact
    txn("wr_devid", 8'h00, 1, 8, 8'h77, -1, 16'h0);
    txn("abort_df", 8'h31, 1, 5, 8'hFF, -1, 16'h0);
    check("abort_df_lit", 32'(data_format), 32'h0000_0000);
    txn("devid2", 8'h80, 1, 8, 8'h00, -1, 16'h0);

    // Address wrap 0x3F -> 0x00
    txn("wrap", 8'hFF, 2, 8, 8'h00, -1, 16'h0);
    check("wrap_lit", 32'(rx_log[$]), 32'h0000_00E5);

    // Reset mid-byte after writing bw_rate
    txn("wr_bw", 8'h2C, 1, 8, 8'h0F, -1, 16'h0);
    check("wr_bw_lit", 32'(bw_rate), 32'h0000_000F);
    spi_cs = 1'b0;
    #(2*HALF);
    spi_bits(8'h80, 8, rx, oe_all, oe_any);
    spi_bits(8'h00, 3, rx, oe_all, oe_any);
    rst_n = 1'b0;
    #20;
    model_reset();
    check_idle("midreset");
    spi_sclk = 1'b1;
    spi_cs = 1'b1;
    #100;
    rst_n = 1'b1;
    #200;
    txn("post_reset_bw", 8'hAC, 1, 8, 8'h00, -1, 16'h0);
    txn("post_reset_id", 8'h80, 1, 8, 8'h00, -1, 16'h0);

    // Randomised transactions
    for (int n = 0; n < 16; n++) begin
      x_axis = 16'($urandom_range(0, 65535));
      y_axis = 16'($urandom_range(0, 65535));
      z_axis = 16'($urandom_range(0, 65535));
      cmd = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), picks[$urandom_range(0, 11)]};
      nbytes = $urandom_range(1, 3);
      last_bits = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
      txn($sformatf("rnd%0d", n), cmd, nbytes, last_bits,
          8'($urandom_range(0, 255)), -1, 16'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
